// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM transaction arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH
  } arb_state_e;

  typedef enum logic {
    PORT_DISP = 1'b0,
    PORT_CPU  = 1'b1
  } port_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and controller signals of the arbiter; slave is the arbiter side.
interface sdram_arbiter_if;
  import sdram_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic              disp_done;

  logic              ctl_start;
  logic              ctl_write_en;
  logic              ctl_burst_en;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_data_in;
  logic [DATA_W-1:0] ctl_data_out;
  logic              ctl_data_ready;
  logic              ctl_mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_done, cpu_rdata,
    input  disp_req, disp_addr,
    output disp_ack, disp_done,
    output ctl_start, ctl_write_en, ctl_burst_en, ctl_addr, ctl_data_in,
    input  ctl_data_out, ctl_data_ready, ctl_mem_ready
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_done, cpu_rdata,
    output disp_req, disp_addr,
    input  disp_ack, disp_done,
    input  ctl_start, ctl_write_en, ctl_burst_en, ctl_addr, ctl_data_in,
    output ctl_data_out, ctl_data_ready, ctl_mem_ready
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Winner selection: display first, CPU once display has run its consecutive quota.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int DISP_MAX_CONSEC = 4,
  parameter int CNT_W           = 3
) (
  input  logic             cpu_req,
  input  logic             disp_req,
  input  logic [CNT_W-1:0] consec,
  output logic             gnt_vld,
  output port_e            gnt_port
);

  always_comb begin
    gnt_vld  = cpu_req | disp_req;
    gnt_port = PORT_DISP;
    if (cpu_req && (!disp_req || consec == CNT_W'(DISP_MAX_CONSEC)))
      gnt_port = PORT_CPU;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Grants the single sdram_ctl port to display bursts or CPU words, one transaction
// at a time, and sequences the controller's start / data_ready handshake.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int DISP_MAX_CONSEC = 4,
  parameter int WAIT_TIMEOUT    = 63
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus,
  output logic           busy,
  output logic           err
);

  localparam int CNT_W = $clog2(DISP_MAX_CONSEC + 1);
  localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);

  arb_state_e        state, state_d;
  logic [CNT_W-1:0]  consec, consec_d;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
  logic              gnt_vld, grant, complete, timeout;
  port_e             gnt_port;

  logic              cpu_ack_d, cpu_done_d, disp_ack_d, disp_done_d;
  logic              ctl_start_d, ctl_write_en_d, ctl_burst_en_d, busy_d, err_d;
  logic [ADDR_W-1:0] ctl_addr_d;
  logic [DATA_W-1:0] ctl_data_in_d, cpu_rdata_d;

  sdram_arb_pick #(
    .DISP_MAX_CONSEC (DISP_MAX_CONSEC),
    .CNT_W           (CNT_W)
  ) u_pick (
    .cpu_req  (bus.cpu_req),
    .disp_req (bus.disp_req),
    .consec   (consec),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      consec           <= '0;
      tmo_cnt          <= '0;
      bus.cpu_ack      <= 1'b0;
      bus.cpu_done     <= 1'b0;
      bus.disp_ack     <= 1'b0;
      bus.disp_done    <= 1'b0;
      bus.ctl_start    <= 1'b0;
      bus.ctl_write_en <= 1'b0;
      bus.ctl_burst_en <= 1'b0;
      bus.ctl_addr     <= '0;
      bus.ctl_data_in  <= '0;
      bus.cpu_rdata    <= '0;
      busy             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= state_d;
      consec           <= consec_d;
      tmo_cnt          <= tmo_cnt_d;
      bus.cpu_ack      <= cpu_ack_d;
      bus.cpu_done     <= cpu_done_d;
      bus.disp_ack     <= disp_ack_d;
      bus.disp_done    <= disp_done_d;
      bus.ctl_start    <= ctl_start_d;
      bus.ctl_write_en <= ctl_write_en_d;
      bus.ctl_burst_en <= ctl_burst_en_d;
      bus.ctl_addr     <= ctl_addr_d;
      bus.ctl_data_in  <= ctl_data_in_d;
      bus.cpu_rdata    <= cpu_rdata_d;
      busy             <= busy_d;
      err              <= err_d;
    end
  end

  // Next state; a falling data_ready takes precedence over a same-cycle timeout
  always_comb begin
    state_d  = state;
    grant    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.ctl_mem_ready && bus.ctl_data_ready && gnt_vld) begin
          grant   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.ctl_data_ready) begin
          state_d = ST_WAIT_LOW;
        end else if (tmo_cnt == TMO_W'(WAIT_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        if (bus.ctl_data_ready) begin
          complete = 1'b1;
          state_d  = ST_WAIT_HIGH;
        end else if (tmo_cnt == TMO_W'(WAIT_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_HIGH: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; ctl_burst_en doubles as the owner id
  always_comb begin
    cpu_ack_d      = 1'b0;
    disp_ack_d     = 1'b0;
    cpu_done_d     = 1'b0;
    disp_done_d    = 1'b0;
    ctl_write_en_d = bus.ctl_write_en;
    ctl_burst_en_d = bus.ctl_burst_en;
    ctl_addr_d     = bus.ctl_addr;
    ctl_data_in_d  = bus.ctl_data_in;
    cpu_rdata_d    = bus.cpu_rdata;
    consec_d       = consec;
    tmo_cnt_d      = '0;

    if ((state == ST_ISSUE || state == ST_WAIT_LOW) && state_d == state)
      tmo_cnt_d = tmo_cnt + 1'b1;

    if (grant) begin
      if (gnt_port == PORT_CPU) begin
        cpu_ack_d      = 1'b1;
        ctl_write_en_d = bus.cpu_we;
        ctl_burst_en_d = 1'b0;
        ctl_addr_d     = bus.cpu_addr;
        ctl_data_in_d  = bus.cpu_wdata;
        consec_d       = '0;
      end else begin
        disp_ack_d     = 1'b1;
        ctl_write_en_d = 1'b0;
        ctl_burst_en_d = 1'b1;
        ctl_addr_d     = bus.disp_addr;
        ctl_data_in_d  = '0;
        if (bus.cpu_req && consec != CNT_W'(DISP_MAX_CONSEC))
          consec_d = consec + 1'b1;
      end
    end

    if (complete || timeout) begin
      disp_done_d = bus.ctl_burst_en;
      cpu_done_d  = !bus.ctl_burst_en;
    end

    // Read data is sampled alongside data_ready so it is valid during cpu_done
    if (complete && !bus.ctl_burst_en && !bus.ctl_write_en)
      cpu_rdata_d = bus.ctl_data_out;

    ctl_start_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
    err_d       = err | timeout;
  end

endmodule
